stack_prog_loader: RTL and testbench

Byte-stream program loader for the stack CPU's instruction memory. Accepts a framed program image over a valid/ready byte interface, assembles bytes into instruction words, writes them sequentially from address 0, and verifies an 8-bit checksum. It holds the CPU in reset while loading and releases it on a good frame, so a host can download programs at run time instead of relying only on the file loaded at elaboration.

---
 rtl/stack_prog_loader.sv | 150 +++++++++++++++
 tb/tb_stack_prog_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stack_prog_loader.sv
// Framed byte-stream loader for the stack CPU instruction memory.
// Assembles MSB-first words, writes them from address 0, verifies an 8-bit sum checksum.
module stack_prog_loader #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned BPW       = DATA_WIDTH / 8;
    localparam int unsigned BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam int unsigned CNTW      = (CW > 9) ? CW : 9;
    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;
    localparam logic [7:0]  HEADER    = 8'hA5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]            state,     state_nxt;
    logic [7:0]            count,     count_nxt;
    logic [CW-1:0]         word_cnt,  word_cnt_nxt;
    logic [BCW-1:0]        byte_cnt,  byte_cnt_nxt;
    logic [DATA_WIDTH-1:0] word_reg,  word_reg_nxt;
    logic [7:0]            acc,       acc_nxt;
    logic                  in_ready_nxt;
    logic                  mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  cpu_hold_nxt;
    logic                  done_nxt;
    logic                  error_nxt;

    logic                  accept;
    logic [DATA_WIDTH-1:0] word_shift;

    assign accept     = in_valid && in_ready;
    assign word_shift = (word_reg << 8) | DATA_WIDTH'(in_data);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_reg  <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= HOLD_AT_RESET;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            word_cnt  <= word_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            word_reg  <= word_reg_nxt;
            acc       <= acc_nxt;
            in_ready  <= in_ready_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_hold  <= cpu_hold_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        word_cnt_nxt  = word_cnt;
        byte_cnt_nxt  = byte_cnt;
        word_reg_nxt  = word_reg;
        acc_nxt       = acc;
        in_ready_nxt  = 1'b1;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        if (accept) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_data == HEADER) begin
                        state_nxt = S_COUNT;
                    end
                end
                S_COUNT: begin
                    count_nxt    = in_data;
                    word_cnt_nxt = '0;
                    byte_cnt_nxt = '0;
                    acc_nxt      = '0;
                    if (32'(in_data) > MAX_WORDS) begin
                        state_nxt = S_ERR;
                    end else if (in_data == 8'h00) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    word_reg_nxt = word_shift;
                    acc_nxt      = acc + in_data;
                    if (byte_cnt == BCW'(BPW - 1)) begin
                        byte_cnt_nxt  = '0;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = word_cnt[ADDR_WIDTH-1:0];
                        mem_wdata_nxt = word_shift;
                        word_cnt_nxt  = word_cnt + CW'(1);
                        if (CNTW'(word_cnt) + CNTW'(1) == CNTW'(count)) begin
                            state_nxt = S_CHECK;
                        end
                    end else begin
                        byte_cnt_nxt = byte_cnt + BCW'(1);
                    end
                end
                S_CHECK: begin
                    state_nxt = (in_data == acc) ? S_DONE : S_ERR;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // Status flags follow the state being entered so they land with it
        done_nxt     = (state_nxt == S_DONE);
        error_nxt    = (state_nxt == S_ERR);
        cpu_hold_nxt = (state_nxt == S_IDLE) ? HOLD_AT_RESET : (state_nxt != S_DONE);
    end

endmodule

// File: tb/tb_stack_prog_loader.sv
// Directed bench for stack_prog_loader: expected memory writes go through a scoreboard queue.
module tb_stack_prog_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    logic          h_ready, h_we, h_hold, h_done, h_error;
    logic [7:0]    h_addr;
    logic [DW-1:0] h_wdata;

    int checks   = 0;
    int failures = 0;
    int cycles   = 0;
    bit throttle = 1'b0;

    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    stack_prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLD_AT_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    // Default-parameter instance, never fed, used for the held-at-reset behaviour
    stack_prog_loader dut_h (
        .clk(clk), .rst(rst), .in_data(8'h00), .in_valid(1'b0), .in_ready(h_ready),
        .mem_we(h_we), .mem_addr(h_addr), .mem_wdata(h_wdata),
        .cpu_hold(h_hold), .done(h_done), .error(h_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"},  32'(done),     32'(d));
        check({tag, "_error"}, 32'(error),    32'(e));
        check({tag, "_hold"},  32'(cpu_hold), 32'(h));
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Sends n bytes taken MSB-first from v
    task automatic send(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            check("in_ready", 32'(in_ready), 32'd1);
            in_data  = v[(n - 1 - i) * 8 +: 8];
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (throttle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Write monitor: every mem_we pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [AW+DW-1:0] e;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", mem_addr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
                check("wr_data", 32'(mem_wdata), 32'(e[DW-1:0]));
            end
        end
    end

    always @(posedge clk) begin
        cycles++;
        if (cycles > 20000) begin
            $display("FAIL watchdog observed=%0d cycles expected=<20000", cycles);
            $fatal(1, "watchdog");
        end
    end

    initial begin
        rst      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_wdata",    32'(mem_wdata), 32'd0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_hold_default", 32'(h_hold), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("hold_default_idle", 32'(h_hold), 32'd1);

        // Good load
        exp_wr(4'd0, 16'h1234);
        exp_wr(4'd1, 16'hABCD);
        send(64'hA5, 1);
        flags("good_hdr", 1'b0, 1'b0, 1'b1);
        send(64'h02_1234_ABCD, 5);
        flags("good_pre", 1'b0, 1'b0, 1'b1);
        send(64'hBE, 1);
        flags("good", 1'b1, 1'b0, 1'b0);
        drain("good");

        // Bad checksum, then empty frame
        exp_wr(4'd0, 16'h1234);
        exp_wr(4'd1, 16'hABCD);
        send(64'hA5_02_1234_ABCD_BF, 7);
        flags("badsum", 1'b0, 1'b1, 1'b1);
        drain("badsum");
        send(64'hA5, 1);
        flags("err_hdr", 1'b0, 1'b0, 1'b1);
        send(64'h00_00, 2);
        flags("empty", 1'b1, 1'b0, 1'b0);
        drain("empty");

        // Resync: leading junk is discarded, A5 inside the frame is data
        send(64'h00_FF_5A, 3);
        flags("junk", 1'b1, 1'b0, 1'b0);
        exp_wr(4'd0, 16'h00A5);
        send(64'hA5_01_00A5_A5, 5);
        flags("resync", 1'b1, 1'b0, 1'b0);
        drain("resync");

        // Oversize count, then the largest legal frame
        send(64'hA5_11, 2);
        flags("oversize", 1'b0, 1'b1, 1'b1);
        drain("oversize");
        send(64'hA5_10, 2);
        for (int i = 0; i < 16; i++) begin
            exp_wr(AW'(i), 16'h0001);
            send(64'h0001, 2);
        end
        flags("full_pre", 1'b0, 1'b0, 1'b1);
        send(64'h10, 1);
        flags("full", 1'b1, 1'b0, 1'b0);
        drain("full");

        // Reset mid-frame leaves only the completed word written
        exp_wr(4'd0, 16'h1234);
        send(64'hA5_02_1234_AB, 5);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        flags("midrst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_wr(4'd0, 16'h0007);
        send(64'hA5_01_0007_07, 5);
        flags("after_rst", 1'b1, 1'b0, 1'b0);
        drain("after_rst");

        // Throttled good load
        throttle = 1'b1;
        exp_wr(4'd0, 16'h1234);
        exp_wr(4'd1, 16'hABCD);
        send(64'hA5, 1);
        flags("thr_hdr", 1'b0, 1'b0, 1'b1);
        send(64'h02_1234_ABCD_BE, 6);
        flags("thr", 1'b1, 1'b0, 1'b0);
        throttle = 1'b0;
        drain("thr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
